video_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor to the fixed 64x32 HD/VD counter.

---
 rtl/video_timing_gen.sv | 184 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: hsync/vsync/de, pixel coordinates and line/frame strobes.
// Optional TG_FRAME_CNT_EN adds a 32-bit frame counter output (frame_cnt).
module video_timing_gen #(
    parameter int HW       = 16,
    parameter int VW       = 13,
    parameter int H_ACTIVE = 48,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 6,
    parameter int H_BP     = 6,
    parameter int V_ACTIVE = 24,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 3,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [HW-1:0] cfg_h_active,
    input  logic [HW-1:0] cfg_h_fp,
    input  logic [HW-1:0] cfg_h_sync,
    input  logic [HW-1:0] cfg_h_bp,
    input  logic [VW-1:0] cfg_v_active,
    input  logic [VW-1:0] cfg_v_fp,
    input  logic [VW-1:0] cfg_v_sync,
    input  logic [VW-1:0] cfg_v_bp,
    input  logic          cfg_load,
    output logic          cfg_busy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          sol,
    output logic          sof,
    output logic          eol,
    output logic          eof
`ifdef TG_FRAME_CNT_EN
    ,
    output logic [31:0]   frame_cnt
`endif
);

    localparam logic HS_LVL = (HS_POL != 0);
    localparam logic VS_LVL = (VS_POL != 0);

    logic [HW-1:0] h_act_r, h_fp_r, h_sync_r, h_bp_r;
    logic [VW-1:0] v_act_r, v_fp_r, v_sync_r, v_bp_r;
    logic [HW-1:0] pend_h_act_r, pend_h_fp_r, pend_h_sync_r, pend_h_bp_r;
    logic [VW-1:0] pend_v_act_r, pend_v_fp_r, pend_v_sync_r, pend_v_bp_r;
    logic [HW-1:0] hc_r;
    logic [VW-1:0] vc_r;

    logic [HW+1:0] h_tot_s, hs_beg_s, hs_end_s, hc_ext_s;
    logic [VW+1:0] v_tot_s, vs_beg_s, vs_end_s, vc_ext_s;
    logic          h_last_s, v_last_s, boundary_s;
    logic          de_s, hs_on_s, vs_on_s;

    // Phase boundaries and position decode from the live (shadow) timing
    always_comb begin
        h_tot_s    = {2'b00, h_act_r} + {2'b00, h_fp_r} + {2'b00, h_sync_r} + {2'b00, h_bp_r};
        hs_beg_s   = {2'b00, h_act_r} + {2'b00, h_fp_r};
        hs_end_s   = hs_beg_s + {2'b00, h_sync_r};
        v_tot_s    = {2'b00, v_act_r} + {2'b00, v_fp_r} + {2'b00, v_sync_r} + {2'b00, v_bp_r};
        vs_beg_s   = {2'b00, v_act_r} + {2'b00, v_fp_r};
        vs_end_s   = vs_beg_s + {2'b00, v_sync_r};
        hc_ext_s   = {2'b00, hc_r};
        vc_ext_s   = {2'b00, vc_r};
        h_last_s   = (hc_ext_s == (h_tot_s - {{(HW+1){1'b0}}, 1'b1}));
        v_last_s   = (vc_ext_s == (v_tot_s - {{(VW+1){1'b0}}, 1'b1}));
        boundary_s = en && h_last_s && v_last_s;
        de_s       = (hc_ext_s < {2'b00, h_act_r}) && (vc_ext_s < {2'b00, v_act_r});
        hs_on_s    = (hc_ext_s >= hs_beg_s) && (hc_ext_s < hs_end_s);
        vs_on_s    = (vc_ext_s >= vs_beg_s) && (vc_ext_s < vs_end_s);
    end

    // Raster position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_r <= {HW{1'b0}};
            vc_r <= {VW{1'b0}};
        end else if (en) begin
            if (h_last_s) begin
                hc_r <= {HW{1'b0}};
                vc_r <= v_last_s ? {VW{1'b0}} : (vc_r + {{(VW-1){1'b0}}, 1'b1});
            end else begin
                hc_r <= hc_r + {{(HW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Pending capture and frame-boundary swap into the shadow timing
    always_ff @(posedge clk) begin
        if (rst) begin
            h_act_r       <= HW'(H_ACTIVE);
            h_fp_r        <= HW'(H_FP);
            h_sync_r      <= HW'(H_SYNC);
            h_bp_r        <= HW'(H_BP);
            v_act_r       <= VW'(V_ACTIVE);
            v_fp_r        <= VW'(V_FP);
            v_sync_r      <= VW'(V_SYNC);
            v_bp_r        <= VW'(V_BP);
            pend_h_act_r  <= {HW{1'b0}};
            pend_h_fp_r   <= {HW{1'b0}};
            pend_h_sync_r <= {HW{1'b0}};
            pend_h_bp_r   <= {HW{1'b0}};
            pend_v_act_r  <= {VW{1'b0}};
            pend_v_fp_r   <= {VW{1'b0}};
            pend_v_sync_r <= {VW{1'b0}};
            pend_v_bp_r   <= {VW{1'b0}};
            cfg_busy      <= 1'b0;
        end else if (boundary_s) begin
            // A load landing on the boundary itself bypasses the pending stage
            if (cfg_load) begin
                h_act_r  <= cfg_h_active;
                h_fp_r   <= cfg_h_fp;
                h_sync_r <= cfg_h_sync;
                h_bp_r   <= cfg_h_bp;
                v_act_r  <= cfg_v_active;
                v_fp_r   <= cfg_v_fp;
                v_sync_r <= cfg_v_sync;
                v_bp_r   <= cfg_v_bp;
            end else if (cfg_busy) begin
                h_act_r  <= pend_h_act_r;
                h_fp_r   <= pend_h_fp_r;
                h_sync_r <= pend_h_sync_r;
                h_bp_r   <= pend_h_bp_r;
                v_act_r  <= pend_v_act_r;
                v_fp_r   <= pend_v_fp_r;
                v_sync_r <= pend_v_sync_r;
                v_bp_r   <= pend_v_bp_r;
            end
            cfg_busy <= 1'b0;
        end else if (cfg_load) begin
            pend_h_act_r  <= cfg_h_active;
            pend_h_fp_r   <= cfg_h_fp;
            pend_h_sync_r <= cfg_h_sync;
            pend_h_bp_r   <= cfg_h_bp;
            pend_v_act_r  <= cfg_v_active;
            pend_v_fp_r   <= cfg_v_fp;
            pend_v_sync_r <= cfg_v_sync;
            pend_v_bp_r   <= cfg_v_bp;
            cfg_busy      <= 1'b1;
        end
    end

    // Registered output decode, one cycle behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= {HW{1'b0}};
            y     <= {VW{1'b0}};
            de    <= 1'b0;
            hsync <= ~HS_LVL;
            vsync <= ~VS_LVL;
            sol   <= 1'b0;
            sof   <= 1'b0;
            eol   <= 1'b0;
            eof   <= 1'b0;
        end else if (en) begin
            x     <= hc_r;
            y     <= vc_r;
            de    <= de_s;
            hsync <= hs_on_s ? HS_LVL : ~HS_LVL;
            vsync <= vs_on_s ? VS_LVL : ~VS_LVL;
            sol   <= (hc_r == {HW{1'b0}});
            sof   <= (hc_r == {HW{1'b0}}) && (vc_r == {VW{1'b0}});
            eol   <= h_last_s;
            eof   <= h_last_s && v_last_s;
        end
    end

`ifdef TG_FRAME_CNT_EN
    // Completed-frame counter, advancing alongside eof
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 32'd0;
        end else if (boundary_s) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed self-checking bench for video_timing_gen with default parameters.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rst, en, cfg_load;
    logic [15:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [12:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic        cfg_busy, hsync, vsync, de, sol, sof, eol, eof;
    logic [15:0] x;
    logic [12:0] y;
`ifdef TG_FRAME_CNT_EN
    logic [31:0] frame_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    video_timing_gen dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_load(cfg_load), .cfg_busy(cfg_busy), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .sol(sol), .sof(sof), .eol(eol), .eof(eof)
`ifdef TG_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb);
        cfg_h_active = 16'(ha); cfg_h_fp = 16'(hf); cfg_h_sync = 16'(hs); cfg_h_bp = 16'(hb);
        cfg_v_active = 13'(va); cfg_v_fp = 13'(vf); cfg_v_sync = 13'(vs); cfg_v_bp = 13'(vb);
    endtask

    task automatic pulse_load();
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    // Advance until eof is shown; returns steps taken, 'hit' low if the budget ran out
    task automatic wait_eof(input int budget, output int cnt, output logic hit);
        cnt = 0;
        while (!eof && cnt < budget) begin
            step();
            cnt++;
        end
        hit = eof;
    endtask

    initial begin
        int cnt, de_cnt, hs_cnt, vs_cnt, eof_cnt, bad_hs, bad_vs, bad_de, busy_drop, first_sol;
        logic hit;

        rst = 1'b1; en = 1'b1; cfg_load = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        check("rst_de", de, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_xy", {x, y}, 0);
        check("rst_sof", sof, 0);
        check("rst_busy", cfg_busy, 0);

        // 1. Default timing over one full 64x32 frame
        rst = 1'b0;
        step();
        check("first_xy", {x, y}, 0);
        check("first_strobes", {de, sof, sol}, 3'b111);
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; eof_cnt = 0; bad_hs = 0; bad_vs = 0; bad_de = 0;
        for (int i = 0; i < 2048; i++) begin
            de_cnt  += int'(de);
            hs_cnt  += int'(hsync);
            vs_cnt  += int'(vsync);
            eof_cnt += int'(eof);
            if (hsync != ((x >= 16'd52) && (x <= 16'd57))) bad_hs++;
            if (vsync != ((y >= 13'd26) && (y <= 13'd28))) bad_vs++;
            if (de != ((x < 16'd48) && (y < 13'd24))) bad_de++;
            step();
        end
        check("t1_de_cnt", de_cnt, 1152);
        check("t1_hs_cnt", hs_cnt, 192);
        check("t1_vs_cnt", vs_cnt, 192);
        check("t1_eof_cnt", eof_cnt, 1);
        check("t1_hs_pos", bad_hs, 0);
        check("t1_vs_pos", bad_vs, 0);
        check("t1_de_pos", bad_de, 0);
        check("t1_wrap_sof", {sof, x, y}, {1'b1, 29'd0});

        // 2. Reload at y=10: old timing to end of frame, then 12x7
        for (int i = 0; i < 640; i++) step();
        check("t2_at_y10", {x, y}, {16'd0, 13'd10});
        set_cfg(8, 1, 2, 1, 4, 1, 1, 1);
        pulse_load();
        check("t2_busy", cfg_busy, 1);
        cnt = 0; busy_drop = 0;
        while (!eof && cnt < 3000) begin
            if (!cfg_busy) busy_drop++;
            step();
            cnt++;
        end
        check("t2_eof_reached", eof, 1);
        check("t2_steps_to_eof", cnt, 1406);
        check("t2_busy_held", busy_drop, 0);
        check("t2_eof_x", x, 63);
        check("t2_busy_clear", cfg_busy, 0);
        step();
        check("t2_sof", sof, 1);
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; eof_cnt = 0; bad_hs = 0;
        for (int i = 0; i < 84; i++) begin
            de_cnt  += int'(de);
            hs_cnt  += int'(hsync);
            vs_cnt  += int'(vsync);
            eof_cnt += int'(eof);
            if (hsync != ((x == 16'd9) || (x == 16'd10))) bad_hs++;
            step();
        end
        check("t2_de_cnt", de_cnt, 32);
        check("t2_hs_cnt", hs_cnt, 14);
        check("t2_vs_cnt", vs_cnt, 12);
        check("t2_eof_cnt", eof_cnt, 1);
        check("t2_hs_pos", bad_hs, 0);
        check("t2_frame84", {sof, x, y}, {1'b1, 29'd0});

        // 3. Zero-length porches: H=4/0/1/0
        set_cfg(4, 0, 1, 0, 4, 1, 1, 1);
        pulse_load();
        check("t3_busy", cfg_busy, 1);
        wait_eof(200, cnt, hit);
        check("t3_eof_reached", hit, 1);
        step();
        check("t3_sof", sof, 1);
        for (int i = 0; i < 5; i++) begin
            check("t3_x", x, i);
            check("t3_de", de, (i < 4) ? 1 : 0);
            check("t3_hsync", hsync, (i == 4) ? 1 : 0);
            step();
        end
        check("t3_line5", {sol, x}, {1'b1, 16'd0});

        // 4. Load on the boundary cycle itself: applied directly, busy never set
        cnt = 0;
        while (!((x == 16'd3) && (y == 13'd6)) && cnt < 100) begin
            step();
            cnt++;
        end
        check("t4_found_pre_eof", {x, y}, {16'd3, 13'd6});
        set_cfg(48, 4, 6, 6, 24, 2, 3, 3);
        pulse_load();
        check("t4_eof", {eof, x}, {1'b1, 16'd4});
        check("t4_busy_eof", cfg_busy, 0);
        step();
        check("t4_sof", sof, 1);
        check("t4_busy_after", cfg_busy, 0);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!sol && cnt < 200);
        check("t4_line64", cnt, 64);

        // 5. Enable held low for 7 cycles at x=20
        cnt = 0;
        while (x != 16'd20 && cnt < 100) begin
            step();
            cnt++;
        end
        check("t5_at_x20", x, 20);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("t5_hold", {x, de, hsync}, {16'd20, 1'b1, 1'b0});
        end
        en = 1'b1;
        step();
        check("t5_resume", {x, de}, {16'd21, 1'b1});

        // 6. Reset at y=15 discards a pending load
        set_cfg(8, 1, 2, 1, 4, 1, 1, 1);
        pulse_load();
        check("t6_busy", cfg_busy, 1);
        cnt = 0;
        while (y != 13'd15 && cnt < 2000) begin
            step();
            cnt++;
        end
        check("t6_at_y15", y, 15);
        rst = 1'b1;
        step();
        check("t6_rst_outs", {de, hsync, vsync, sol, sof, eol, eof, cfg_busy}, 8'd0);
        check("t6_rst_xy", {x, y}, 0);
`ifdef TG_FRAME_CNT_EN
        check("t6_fc_rst", frame_cnt, 0);
`endif
        rst = 1'b0;
        step();
        check("t6_first", {sof, de, x, y}, {2'b11, 29'd0});
        cnt = 0; first_sol = 0;
        do begin
            step();
            cnt++;
            if (sol && first_sol == 0) first_sol = cnt;
        end while (!sof && cnt < 5000);
        check("t6_line64", first_sol, 64);
        check("t6_frame2048", cnt, 2048);
        check("t6_busy_after", cfg_busy, 0);
`ifdef TG_FRAME_CNT_EN
        for (int i = 0; i < 4096; i++) step();
        check("t6_fc3", frame_cnt, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
